hq_manchester_framer: RTL and testbench
=======================================

# hq_manchester_framer

Parametrised HaveQuick time-of-day frame serializer: on a `start` pulse (1PPS-derived) it captures a GNSS time payload (default week number and time-of-week seconds), prepends a sync word, optionally appends even parity, and shifts the frame out MSB-first as Manchester-coded serial data. It sits between the GNSS time formatter and the HaveQuick line driver. It generalises the fixed-format encoder in four ways:
- configurable payload width, sync word, bit rate and Manchester polarity;
- busy/done handshake;
- overrun reporting;
- optional parity.

## Interface
- `HALF_BIT_CYCLES`, 41667, clock cycles per Manchester half-bit (1200 bps at 100 MHz); minimum 2.
- `SYNC_W`, 16, sync word width; minimum 1.
- `SYNC_WORD`, 16'hEB90, sync pattern, sent MSB first.
- `PAYLOAD_W`, 30, payload width (default {wn10[9:0], tow_sec[19:0]}).
- `MANCH_POL`, 0, encoding polarity:
  - 0: bit 1 = high then low, bit 0 = low then high.
  - 1: inverted.
- `IDLE_LEVEL`, 0, line level while not transmitting.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle frame request.
- `payload`  in  PAYLOAD_W  frame data; sampled only in the accept cycle.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `overrun`  out  1  one-cycle pulse when `start` is rejected.
- `manchester_out`  out  1  serial line.

## Operation
- States: IDLE, SYNC, DATA, PAR (present only with parity compiled in).
- IDLE + `start`=1 (accept cycle):
  - latch `payload` into the shift register;
  - load sync into the sync shifter;
  - reset the half-bit counter;
  - go to SYNC.
- SYNC: send `SYNC_W` bits, then go to DATA.
- DATA: send `PAYLOAD_W` bits, then go to PAR, or go to IDLE when parity is compiled out.
- PAR: send 1 bit, then go to IDLE.
- Each bit occupies two half-bits:
  - first half = bit XOR `MANCH_POL`;
  - second half = its inverse.
- Half-bit counter runs 0..`HALF_BIT_CYCLES`-1 and wraps. Phase toggles on wrap; the bit advances when the second half wraps.
- `start` while `busy`=1: ignored, `overrun` pulses the next cycle, the current frame is unaffected.
- `start` in the cycle `done` is high: `busy` is already 0, so the request is accepted (back-to-back frames).
- Changes to `payload` after the accept cycle have no effect on the frame.
- Counter widths:
  - half-bit counter: $clog2(`HALF_BIT_CYCLES`);
  - bit counter: $clog2(`SYNC_W`+`PAYLOAD_W`+2).
- All counters are unsigned and never overflow their terminal compare.

## Timing
- Reset values: `busy`=0, `done`=0, `overrun`=0, `manchester_out`=`IDLE_LEVEL`, state IDLE.
- Reset asserted mid-frame: the next edge aborts the frame, applies the reset values and discards the payload. No `done` is generated.
- Accept at edge N:
  - `busy`=1 from cycle N+1;
  - `manchester_out` drives the first half of sync MSB from cycle N+1.
- Frame length F = `SYNC_W`+`PAYLOAD_W`(+1 with parity) bits; it occupies exactly 2·`HALF_BIT_CYCLES`·F cycles.
- Cycle after the last half-bit:
  - `done`=1;
  - `busy`=0;
  - `manchester_out`=`IDLE_LEVEL`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `HQ_PARITY_EN` defined:
  - PAR state exists;
  - one even-parity bit (XOR of all payload bits) is appended after the payload LSB;
  - F = `SYNC_W`+`PAYLOAD_W`+1.
- `HQ_PARITY_EN` undefined:
  - no PAR state;
  - DATA goes directly to IDLE;
  - F = `SYNC_W`+`PAYLOAD_W`.

## Structure
- Package `hq_pkg` holds:
  - the state enum type;
  - the Manchester polarity constants;
  - the default sync word constant;
  - the default payload width derived from the wn10/tow_sec widths (10+20).
- Sub-module `hq_bit_timer` contains the half-bit counter. It outputs `half_strobe` (counter wrap) and `bit_strobe` (second-half wrap), with a synchronous clear on accept.

## Test plan
All scenarios use `HALF_BIT_CYCLES`=4 and default parameters unless stated.
- Reset 5 cycles, no `start` -> `manchester_out`=0, `busy`=0, `done`=0, `overrun`=0 throughout.
- Payload 0x13A35B67 (wn10=314, tow=220007), single `start`, parity off:
  - decoded stream = 0xEB90 followed by 0x13A35B67;
  - `busy` high for exactly 368 cycles;
  - `done` pulse in the following cycle.
- Same payload with `HQ_PARITY_EN` -> 47 bits, last bit = 1 (popcount 17), `busy` high for 376 cycles.
- `MANCH_POL`=1 -> first 8 line cycles = 0,0,0,0,1,1,1,1 (sync MSB 1 inverted).
- `start` at cycle 100 of a frame -> `overrun`=1 for one cycle; frame bits unchanged; exactly one `done`.
- `rst` at cycle 50 of a frame -> line at `IDLE_LEVEL` next cycle, no `done`. A new `start` then produces a complete, correct frame.

Source files
------------

// File: rtl/hq_pkg.sv
// Shared types and defaults for the HaveQuick time-of-day framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hq_pkg;

    // Frame sequencer states; ST_PAR is only reachable when parity is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } hq_state_e;

    // Manchester polarity: normal sends a 1 as high-then-low.
    localparam logic MANCH_POL_NORMAL = 1'b0;
    localparam logic MANCH_POL_INVERT = 1'b1;

    // Default HaveQuick sync pattern.
    localparam logic [15:0] HQ_SYNC_WORD_DEF = 16'hEB90;

    // Default payload is {week number[9:0], time-of-week seconds[19:0]}.
    localparam int HQ_WN_W          = 10;
    localparam int HQ_TOW_W         = 20;
    localparam int HQ_PAYLOAD_W_DEF = HQ_WN_W + HQ_TOW_W;

endpackage

// File: rtl/hq_bit_timer.sv
// Half-bit timer: strobes once per Manchester half-bit and once per full bit.
// Latency: strobes are combinational from the registered counter; clear takes effect next cycle.
// Backpressure: none; free-runs while enabled.
module hq_bit_timer #(
    parameter int HALF_BIT_CYCLES = 41667
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic half_strobe,
    output logic bit_strobe
);

    localparam int              CW   = $clog2(HALF_BIT_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Wrap of the counter ends a half-bit; a wrap in the second half ends the bit.
    assign half_strobe = en && (cnt_q == LAST);
    assign bit_strobe  = half_strobe && phase_q;

    // Next counter and phase values.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en) begin
            cnt_d   = half_strobe ? '0 : cnt_q + 1'b1;
            phase_d = phase_q ^ half_strobe;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/hq_manchester_framer.sv
// HaveQuick ToD framer: sync word + payload (+ even parity when HQ_PARITY_EN is defined), Manchester coded, MSB first.
// Latency: line carries the first sync half-bit the cycle after start is accepted; done pulses the cycle after the last half-bit.
// Backpressure: none; start while busy is dropped and reported on overrun the following cycle.
module hq_manchester_framer
    import hq_pkg::*;
#(
    parameter int                HALF_BIT_CYCLES = 41667,
    parameter int                SYNC_W          = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD       = SYNC_W'(HQ_SYNC_WORD_DEF),
    parameter int                PAYLOAD_W       = HQ_PAYLOAD_W_DEF,
    parameter logic              MANCH_POL       = MANCH_POL_NORMAL,
    parameter logic              IDLE_LEVEL      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 manchester_out
);

    localparam int             BCW       = $clog2(SYNC_W + PAYLOAD_W + 2);
    localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_W - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(SYNC_W + PAYLOAD_W - 1);

    hq_state_e            state_q, state_d;
    logic [SYNC_W-1:0]    sync_q, sync_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 manch_q, manch_d;
    logic                 next_bit;
    logic                 timer_clr;
    logic                 half_strobe, bit_strobe;
`ifdef HQ_PARITY_EN
    logic                 par_q, par_d;
`endif

    hq_bit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (timer_clr),
        .en         (state_q != ST_IDLE),
        .half_strobe(half_strobe),
        .bit_strobe (bit_strobe)
    );

    // Sequencer: accept/overrun, shifter advance, and the next registered line level.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovr_d     = 1'b0;
        manch_d   = manch_q;
        next_bit  = 1'b0;
        timer_clr = 1'b0;
`ifdef HQ_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d   = ST_SYNC;
                sync_d    = SYNC_WORD;
                data_d    = payload;
                bit_cnt_d = '0;
                busy_d    = 1'b1;
                timer_clr = 1'b1;
                manch_d   = SYNC_WORD[SYNC_W-1] ^ MANCH_POL;
`ifdef HQ_PARITY_EN
                par_d     = ^payload;
`endif
            end
        end else begin
            ovr_d = start;
            // End of the first half: the line flips to the complementary level.
            if (half_strobe && !bit_strobe) begin
                manch_d = ~manch_q;
            end
            if (bit_strobe) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                case (state_q)
                    ST_SYNC: begin
                        sync_d = sync_q << 1;
                        if (bit_cnt_q == SYNC_LAST) begin
                            state_d = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        data_d = data_q << 1;
                        if (bit_cnt_q == DATA_LAST) begin
`ifdef HQ_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end
                    end
`ifdef HQ_PARITY_EN
                    ST_PAR: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                    default: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
                // Level for the first half of whichever bit comes next.
                case (state_d)
                    ST_SYNC: next_bit = sync_d[SYNC_W-1];
                    ST_DATA: next_bit = data_d[PAYLOAD_W-1];
`ifdef HQ_PARITY_EN
                    ST_PAR:  next_bit = par_q;
`endif
                    default: next_bit = 1'b0;
                endcase
                manch_d = (state_d == ST_IDLE) ? IDLE_LEVEL : (next_bit ^ MANCH_POL);
            end
        end
    end

    // State and output registers; reset aborts any frame and discards its payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            manch_q   <= IDLE_LEVEL;
`ifdef HQ_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            manch_q   <= manch_d;
`ifdef HQ_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign overrun        = ovr_q;
    assign manchester_out = manch_q;

endmodule

// File: tb/tb_hq_manchester_framer.sv
// Directed bench for hq_manchester_framer with HALF_BIT_CYCLES=4 (parity follows HQ_PARITY_EN).
// Latency: checks first half-bit one cycle after accept and done one cycle after the frame.
// Backpressure: exercises overrun, back-to-back starts and mid-frame reset.
module tb_hq_manchester_framer;

    localparam int          H         = 4;
    localparam logic [15:0] SYNC      = 16'hEB90;
`ifdef HQ_PARITY_EN
    localparam int          FL        = 47;
`else
    localparam int          FL        = 46;
`endif
    localparam int          FRAME_CYC = 2 * H * FL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [29:0] payload = '0;
    logic        busy, done, overrun, line;
    logic        busy_i, done_i, ovr_i, line_i;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic line_cap [FRAME_CYC];
    logic inv_cap  [8];
    int   done_cnt, ovr_cnt, ovr_k, busy_bad;

    always #5 clk = ~clk;

    hq_manchester_framer #(.HALF_BIT_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .start(start), .payload(payload),
        .busy(busy), .done(done), .overrun(overrun), .manchester_out(line)
    );

    hq_manchester_framer #(.HALF_BIT_CYCLES(H), .MANCH_POL(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .start(start), .payload(payload),
        .busy(busy_i), .done(done_i), .overrun(ovr_i), .manchester_out(line_i)
    );

    typedef struct {
        logic [29:0] payload;
        logic        par;
        int          ovr_at;
        bit          b2b;
        bit          chk_inv;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Sends one frame and checks it; returns sampling at the negedge of the done cycle.
    task automatic run_frame(input logic [29:0] p, input logic par, input int ovr_at,
                             input bit b2b, input bit chk_inv, input string nm);
        logic [FL-1:0] exp_bits, got_bits;
        int            bad_m;
        logic          first;
        if (!b2b) @(negedge clk);
        start   = 1'b1;
        payload = p;
        @(negedge clk);
        start   = 1'b0;
        payload = ~p;
        done_cnt = 0; ovr_cnt = 0; ovr_k = -1; busy_bad = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            line_cap[k] = line;
            if (k < 8) inv_cap[k] = line_i;
            if (!busy)   busy_bad++;
            if (done)    done_cnt++;
            if (overrun) begin ovr_cnt++; ovr_k = k; end
            if (k == ovr_at) begin
                start   = 1'b1;
                payload = 30'($urandom);
            end else begin
                start   = 1'b0;
            end
            @(negedge clk);
        end
        bad_m = 0;
        for (int i = 0; i < FL; i++) begin
            first = line_cap[2*H*i];
            got_bits[FL-1-i] = first;
            for (int j = 0; j < 2*H; j++)
                if (line_cap[2*H*i+j] !== ((j < H) ? first : ~first)) bad_m++;
        end
`ifdef HQ_PARITY_EN
        exp_bits = {SYNC, p, par};
`else
        exp_bits = {SYNC, p};
`endif
        chk({nm, " frame bits"}, 64'(got_bits), 64'(exp_bits));
        chk({nm, " manchester halves"}, 64'(bad_m), 64'd0);
        chk({nm, " busy low in frame"}, 64'(busy_bad), 64'd0);
        chk({nm, " done in frame"}, 64'(done_cnt), 64'd0);
        chk({nm, " done at end"}, 64'(done), 64'd1);
        chk({nm, " busy at end"}, 64'(busy), 64'd0);
        chk({nm, " line at end"}, 64'(line), 64'd0);
        chk({nm, " overrun pulses"}, 64'(ovr_cnt), (ovr_at >= 0) ? 64'd1 : 64'd0);
        if (ovr_at >= 0) chk({nm, " overrun cycle"}, 64'(ovr_k), 64'(ovr_at + 1));
        if (chk_inv)
            chk({nm, " inverted first 8"},
                64'({inv_cap[0], inv_cap[1], inv_cap[2], inv_cap[3],
                     inv_cap[4], inv_cap[5], inv_cap[6], inv_cap[7]}), 64'h0F);
    endtask

    initial begin
        vec_t vecs [5];
        vecs[0] = '{30'h13A35B67, 1'b1, -1,  1'b0, 1'b1};
        vecs[1] = '{30'h3FFFFFFF, 1'b0, -1,  1'b1, 1'b0};
        vecs[2] = '{30'h00000000, 1'b0, 100, 1'b0, 1'b0};
        vecs[3] = '{30'h2AAAAAAA, 1'b1, -1,  1'b1, 1'b0};
        vecs[4] = '{30'h00000001, 1'b1, -1,  1'b0, 1'b0};

        // Reset held for 5 cycles with no start: everything quiet.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("reset outputs", 64'({busy, done, overrun, line, busy_i, done_i, ovr_i, line_i}), 64'd0);
        end
        rst = 1'b0;

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].payload, vecs[v].par, vecs[v].ovr_at, vecs[v].b2b,
                      vecs[v].chk_inv, $sformatf("vec%0d", v));

        // Reset at cycle 50 of a frame aborts it with no done.
        @(negedge clk);
        start   = 1'b1;
        payload = 30'h13A35B67;
        @(negedge clk);
        start   = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset line", 64'(line), 64'd0);
        chk("midreset busy/done", 64'({busy, done}), 64'd0);
        chk("midreset inv line", 64'(line_i), 64'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < FRAME_CYC + 8; c++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        chk("midreset no done/busy after", 64'(done_cnt), 64'd0);

        run_frame(30'h13A35B67, 1'b1, -1, 1'b0, 1'b0, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
